// File: rtl/shiftreg_pkg.sv
// ---------------------------------------------------------------------------
// Package: shiftreg_pkg
//
// Purpose
//   Shared types and helpers for the shift-register family (PISO transmitter
//   and SIPO receiver). Both sides import this package so that the FSM state
//   encoding and the bit-counter sizing rule stay identical.
//
// Contents
//   piso_state_t  two-state FSM encoding for the parallel-in serial-out side
//   cnt_width()   width of a bit counter that must reach w-1, never below 1
// ---------------------------------------------------------------------------
package shiftreg_pkg;

    // IDLE waits for a parallel word; SHIFT presents bits on the serial side.
    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_t;

    // A counter that runs 0 .. w-1 needs $clog2(w) bits, but a one-bit word
    // would give zero bits, so the result is clamped to at least one bit.
    function automatic int cnt_width(input int w);
        int bits;
        bits = $clog2(w);
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage : shiftreg_pkg

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// Module: piso_bit_counter
//
// Purpose
//   Bit-position counter for one serial word. Counts beats from 0 up to MAX
//   and flags when the final position is reached. Shared by the PISO and SIPO
//   sides of the shift-register family for word-boundary detection.
//
// Parameters
//   WIDTH   counter width in bits (at least 1)
//   MAX     terminal count, normally word width - 1
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous reset, active-high, clears count
//   clr     in   1      synchronous clear to 0; wins over inc
//   inc     in   1      advance by one position
//   count   out  WIDTH  current bit position
//   at_max  out  1      count == MAX
// ---------------------------------------------------------------------------
module piso_bit_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    assign at_max = (count == MAX_VAL);

    // Clear has priority so that a word loaded on the same edge as the
    // previous word's final beat starts cleanly at position 0. Incrementing
    // from MAX wraps to 0, which keeps the count inside 0 .. MAX even when
    // the owner drops back to idle after the final beat without a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (at_max) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule : piso_bit_counter

// File: rtl/shiftreg_piso.sv
// ---------------------------------------------------------------------------
// Module: shiftreg_piso
//
// Purpose
//   Parallel-in serial-out shift register with valid/ready handshakes on both
//   sides. A DATA_WIDTH word is taken on the parallel side and sent one bit
//   per accepted serial beat, with flags marking the first and the last bit
//   of every word. A new word can be loaded on the final beat of the current
//   one, so a continuous stream has no idle cycles between words.
//
// Parameters
//   DATA_WIDTH  word width in bits (>= 1)
//   MSB_FIRST   1: bit DATA_WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous reset, ACTIVE-HIGH despite the
//                                name (1 = in reset)
//   in_valid    in   1           parallel word available
//   in_ready    out  1           block accepts a word this cycle
//   in_data     in   DATA_WIDTH  parallel word, sampled on in_valid && in_ready
//   out_serial  out  1           current serial bit
//   out_valid   out  1           serial bit and flags are valid
//   out_ready   in   1           sink consumes the current bit this cycle
//   out_first   out  1           current bit is the first of its word
//   out_last    out  1           current bit is the final bit of its word
//
// Integration note
//   in_ready is combinational from out_ready (and from rst_n): during the
//   final bit of a word the block is ready only if the sink is consuming
//   that bit in the same cycle. Upstream logic must not make in_valid depend
//   combinationally on in_ready, and a sink that derives out_ready from
//   in_valid/in_ready would close a combinational loop.
// ---------------------------------------------------------------------------
module shiftreg_piso
    import shiftreg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_serial,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    piso_state_t           state;
    piso_state_t           next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      count;
    logic                  at_max;
    logic                  load;
    logic                  beat;

    // A word is taken whenever the parallel handshake completes; a serial
    // beat happens whenever the sink takes the presented bit.
    assign load = in_valid && in_ready;
    assign beat = out_valid && out_ready;

    // The bit being presented always sits at the outgoing end of the
    // register. Vacated positions fill with zeros, so after a full word the
    // register is empty and out_serial rests at 0 in IDLE.
    assign out_serial = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];

    // Bit position within the current word. A load restarts at 0; a beat
    // that is not also a load advances it.
    piso_bit_counter #(
        .WIDTH (CNT_W),
        .MAX   (DATA_WIDTH - 1)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst_n),
        .clr    (load),
        .inc    (beat && !load),
        .count  (count),
        .at_max (at_max)
    );

    // FSM state register. Reset is asynchronous so out_valid drops the
    // moment reset is asserted and any partial word is abandoned.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= PISO_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. IDLE leaves on any accepted word. SHIFT stays put
    // until the final beat; a word loaded on that beat keeps the FSM in
    // SHIFT, giving back-to-back words without a bubble.
    always_comb begin
        next_state = state;
        unique case (state)
            PISO_IDLE: begin
                if (load) begin
                    next_state = PISO_SHIFT;
                end
            end
            PISO_SHIFT: begin
                if (beat && at_max && !load) begin
                    next_state = PISO_IDLE;
                end
            end
            default: begin
                next_state = PISO_IDLE;
            end
        endcase
    end

    // Output decode. in_ready is held low while reset is asserted (rst_n is
    // the active-high reset), otherwise it is high in IDLE and on the final
    // beat of a word that the sink is consuming right now.
    always_comb begin
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            PISO_IDLE: begin
                in_ready = !rst_n;
            end
            PISO_SHIFT: begin
                out_valid = 1'b1;
                out_first = (count == '0);
                out_last  = at_max;
                in_ready  = !rst_n && at_max && out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Shift register. Loading takes precedence over shifting, which is what
    // makes the final-beat reload work: the outgoing bit was already
    // consumed, and the new word replaces the register contents entirely.
    // While the sink stalls the register simply holds.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= in_data;
        end else if (beat) begin
            if (MSB_FIRST) begin
                shift_reg <= shift_reg << 1;
            end else begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

endmodule : shiftreg_piso

// File: tb/tb_shiftreg_piso.sv
// ---------------------------------------------------------------------------
// Testbench: tb_shiftreg_piso
//
// Purpose
//   Scoreboard bench for shiftreg_piso. Two instances are exercised: one
//   sending MSB first and one sending LSB first. Stimulus pushes the expected
//   {serial, first, last} triple for every bit into a per-instance queue; a
//   monitor per instance pops and compares whenever that instance completes a
//   serial beat. Directed checks cover reset, ready behaviour and stalls.
// ---------------------------------------------------------------------------
module tb_shiftreg_piso;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       m_in_valid, m_in_ready, m_out_serial, m_out_valid;
    logic       m_out_ready, m_out_first, m_out_last;
    logic [7:0] m_in_data;

    logic       l_in_valid, l_in_ready, l_out_serial, l_out_valid;
    logic       l_out_ready, l_out_first, l_out_last;
    logic [7:0] l_in_data;

    logic [2:0] m_q[$];
    logic [2:0] l_q[$];
    logic [2:0] m_exp;
    logic [2:0] l_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shiftreg_piso #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst),
        .in_valid   (m_in_valid),
        .in_ready   (m_in_ready),
        .in_data    (m_in_data),
        .out_serial (m_out_serial),
        .out_valid  (m_out_valid),
        .out_ready  (m_out_ready),
        .out_first  (m_out_first),
        .out_last   (m_out_last)
    );

    shiftreg_piso #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst),
        .in_valid   (l_in_valid),
        .in_ready   (l_in_ready),
        .in_data    (l_in_data),
        .out_serial (l_out_serial),
        .out_valid  (l_out_valid),
        .out_ready  (l_out_ready),
        .out_first  (l_out_first),
        .out_last   (l_out_last)
    );

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue the expected bits of a word; nbits < 8 models a word cut short.
    task automatic pushWord(input bit sel_lsb, input logic [7:0] data, input int nbits);
        logic [2:0] e;
        for (int i = 0; i < nbits; i++) begin
            e[2] = sel_lsb ? data[i] : data[7-i];
            e[1] = (i == 0);
            e[0] = (i == 7);
            if (sel_lsb) l_q.push_back(e);
            else         m_q.push_back(e);
        end
    endtask

    // Send one isolated word with the sink always ready, then confirm the
    // instance is idle exactly eight beats after acceptance.
    task automatic applyStimulus(input bit sel_lsb, input logic [7:0] data, input string name);
        pushWord(sel_lsb, data, 8);
        if (sel_lsb) begin l_in_valid = 1'b1; l_in_data = data; end
        else         begin m_in_valid = 1'b1; m_in_data = data; end
        @(posedge clk); #1;
        if (sel_lsb) begin l_in_valid = 1'b0; l_in_data = 8'h3C; end
        else         begin m_in_valid = 1'b0; m_in_data = 8'h3C; end
        repeat (8) @(posedge clk);
        #1;
        checkOutput(name, {7'b0, sel_lsb ? l_out_valid : m_out_valid}, 8'h00);
    endtask

    // MSB-first monitor: every completed beat must match the queue head.
    always @(negedge clk) begin
        if (!rst && m_out_valid && m_out_ready) begin
            if (m_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL msb_beat: got unexpected beat %b expected none", {m_out_serial, m_out_first, m_out_last});
            end else begin
                m_exp = m_q.pop_front();
                checkOutput("msb_beat", {5'b0, m_out_serial, m_out_first, m_out_last}, {5'b0, m_exp});
            end
        end
    end

    // LSB-first monitor, same rule.
    always @(negedge clk) begin
        if (!rst && l_out_valid && l_out_ready) begin
            if (l_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL lsb_beat: got unexpected beat %b expected none", {l_out_serial, l_out_first, l_out_last});
            end else begin
                l_exp = l_q.pop_front();
                checkOutput("lsb_beat", {5'b0, l_out_serial, l_out_first, l_out_last}, {5'b0, l_exp});
            end
        end
    end

    initial begin
        m_in_valid = 1'b0; m_in_data = 8'h00; m_out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_data = 8'h00; l_out_ready = 1'b1;

        // Reset held for three clocks, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", {7'b0, m_out_valid}, 8'h00);
        checkOutput("reset_out_serial", {7'b0, m_out_serial}, 8'h00);
        checkOutput("reset_in_ready", {6'b0, m_in_ready, l_in_ready}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_in_ready", {6'b0, m_in_ready, l_in_ready}, 8'h03);
        @(posedge clk); #1;

        // Single words, both bit orders.
        applyStimulus(1'b0, 8'hA5, "msb_a5_idle");
        applyStimulus(1'b1, 8'hA5, "lsb_a5_idle");
        applyStimulus(1'b1, 8'h01, "lsb_01_idle");

        // Back-to-back: F0 then 0F with in_valid held high.
        pushWord(1'b0, 8'hF0, 8);
        pushWord(1'b0, 8'h0F, 8);
        m_in_valid = 1'b1; m_in_data = 8'hF0;
        @(posedge clk); #1;
        m_in_data = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("b2b_in_ready", {7'b0, m_in_ready}, (k == 7) ? 8'h01 : 8'h00);
            @(posedge clk);
        end
        #1;
        m_in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("b2b_idle", {7'b0, m_out_valid}, 8'h00);

        // Backpressure on C3: stall four cycles while bit 2 is presented.
        pushWord(1'b0, 8'hC3, 8);
        m_in_valid = 1'b1; m_in_data = 8'hC3;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_data = 8'h55;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stall_hold", {4'b0, m_out_valid, m_out_serial, m_out_first, m_out_last}, 8'h08);
            checkOutput("stall_in_ready", {7'b0, m_in_ready}, 8'h00);
            @(posedge clk);
        end
        #1;
        m_out_ready = 1'b1;
        m_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("stall_idle", {7'b0, m_out_valid}, 8'h00);

        // Reset mid-word: four bits of FF go out, then the word is dropped.
        pushWord(1'b0, 8'hFF, 4);
        m_in_valid = 1'b1; m_in_data = 8'hFF;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midword_valid_before", {7'b0, m_out_valid}, 8'h01);
        rst = 1'b1;
        #1;
        checkOutput("midword_reset_out", {4'b0, m_out_valid, m_out_serial, m_out_first, m_out_last}, 8'h00);
        checkOutput("midword_reset_in_ready", {7'b0, m_in_ready}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h81, "after_reset_81_idle");

        checkOutput("msb_queue_empty", 8'(m_q.size()), 8'h00);
        checkOutput("lsb_queue_empty", 8'(l_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shiftreg_piso
